charbuf_writer: RTL and testbench
=================================

Name: charbuf_writer

Overview:
- Write-side engine for the 64x32 colour character buffer (16-bit word: [7:0] char code, [15:8] attribute).
- Accepts a byte stream over a valid/ready handshake and maintains a text cursor.
- Interprets four control codes and drives the buffer's write port (address = {row[4:0], col[5:0]}).
- Sits between a byte source (UART RX, CPU register) and the buffer; the VGA scanout owns the read port.

Parameters:
- COLS, 60, visible text columns (1..64); the address stride stays 64.
- ROWS, 17, visible text rows (1..32).

Ports:
- clk  in  1  system clock, also the buffer write clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  byte available.
- in_data  in  8  byte: char code or control code.
- in_attr  in  8  attribute paired with in_data; sampled on accept.
- in_ready  out  1  block can accept a byte this cycle.
- wr_en  out  1  buffer write strobe (drives the write-port clock enable).
- wr_addr  out  11  buffer write address {row, col}.
- wr_data  out  16  {attr, char}.
- cur_col  out  6  cursor column.
- cur_row  out  5  cursor row.
- busy  out  1  a line or screen clear is in progress.

Behaviour:
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cur_col=0, cur_row=0, busy=0, in_ready=1 (state IDLE).
- Accept rule: a byte is accepted when in_valid & in_ready. in_ready=1 only in IDLE. in_data/in_attr are ignored otherwise. The source holds in_valid/in_data until accepted.
- Attribute register: set from in_attr on every accept; it is the fill attribute for clears.
- State machine: IDLE, PUT, CLR_LINE, CLR_SCREEN.
- IDLE, printable byte (anything except 0x08/0x0A/0x0C/0x0D, including 0x00-0x07 and 0x80-0xFF) accepted at cycle N:
  - Cycle N+1: wr_en=1, wr_addr={cur_row,cur_col} as of N, wr_data={in_attr,in_data}; state PUT, in_ready=0.
  - Cursor update, visible at N+1: col+1. If col==COLS-1, then col=0 and row advances.
  - PUT -> IDLE at N+2, unless the row advanced, in which case PUT -> CLR_LINE.
- Row advance: row+1; if row==ROWS-1, row wraps to 0. There is no scroll, because the block has no read port.
- 0x0D (CR): col=0, no write, next cycle stays IDLE; in_ready drops for one cycle.
- 0x0A (LF): col=0, row advances, enter CLR_LINE.
- 0x08 (BS):
  - If col>0: col-1 and write {attr,0x20} at the new position, through PUT.
  - If col==0: no change and no write.
- 0x0C (FF): cursor to (0,0), enter CLR_SCREEN.
- CLR_LINE:
  - busy=1. Writes {attr,0x20} to {cur_row, c} for c=0..COLS-1, one per cycle (COLS cycles).
  - Then IDLE. The cursor stays at (row,0).
- CLR_SCREEN:
  - busy=1. Row-major writes of {attr,0x20} to all r<ROWS, c<COLS: ROWS*COLS cycles.
  - Addresses with c>=COLS or r>=ROWS are never written.
  - Then IDLE.
- wr_en is never asserted outside PUT/CLR_* and never for more than one write per cycle.
- Reset mid-clear: aborts immediately; outputs return to reset values. Partially cleared content stays.
- A cursor width of 6/5 bits holds COLS-1 / ROWS-1 for any legal parameter value.

Optional Feature:
- Macro CHARBUF_CLEAR_ON_RESET_EN.
- Defined: after reset release the FSM starts in CLR_SCREEN with attr=0x07. busy=1 and in_ready=0 for ROWS*COLS cycles, then IDLE.
- Not defined: the FSM starts in IDLE and the buffer keeps its power-on contents.

Test Plan:
- Reset, then send 'A' (0x41, attr 0x0F) -> exactly one write: addr 0x000, data 0x0F41. cur_col=1. in_ready low for one cycle.
- Send 60 printable bytes at row 0 -> last write at addr 0x03B. Cursor goes to (row 1, col 0). Then 60 writes of {attr,0x20} to 0x040..0x07B, busy=1 throughout.
- Cursor at (16,5), send 0x0A -> cursor (0,0). Row 0 is cleared at 0x000..0x03B. No write to row 16.
- Cursor at (0,3), send 0x08 then 0x08 at col 0 -> the first writes 0x20 at 0x002 with col=2. At col 0 a BS causes no write.
- Send 0x0C with attr 0x17 -> 1020 writes of 0x1720, none to col>=60 or row>=17. Cursor (0,0). in_ready returns high after the last write.
- Assert rst during CLR_SCREEN -> wr_en=0 the same cycle (async), cursor 0. With CHARBUF_CLEAR_ON_RESET_EN, a fresh clear of 1020 writes of 0x0720 follows release.

Source files
------------

// File: rtl/charbuf_writer.sv
// Write-side engine for the 64x32 character buffer: byte stream in, cursor-tracked buffer writes out.
// Optional CHARBUF_CLEAR_ON_RESET_EN: clear the whole screen with attribute 0x07 after reset.
module charbuf_writer #(
    parameter int COLS = 60,
    parameter int ROWS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_attr,
    output logic        in_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    localparam logic [5:0] COL_MAX = 6'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_SCREEN} state_t;

    state_t     state;
    logic [7:0] attr;
    logic       adv_pending;
    logic       accept;

    assign accept = in_valid & in_ready;

    function automatic logic [4:0] next_row(input logic [4:0] r);
        return (r == ROW_MAX) ? 5'd0 : r + 5'd1;
    endfunction

    // Clear sweeps walk wr_addr itself, so no separate clear counters exist.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en       <= 1'b0;
            wr_addr     <= 11'd0;
            wr_data     <= 16'd0;
            cur_col     <= 6'd0;
            cur_row     <= 5'd0;
            adv_pending <= 1'b0;
`ifdef CHARBUF_CLEAR_ON_RESET_EN
            state       <= CLR_SCREEN;
            busy        <= 1'b1;
            in_ready    <= 1'b0;
            attr        <= 8'h07;
`else
            state       <= IDLE;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
            attr        <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wr_en    <= 1'b0;
                    in_ready <= 1'b1;
                    if (accept) begin
                        attr     <= in_attr;
                        in_ready <= 1'b0;
                        case (in_data)
                            CH_CR: cur_col <= 6'd0;
                            CH_LF: begin
                                cur_col <= 6'd0;
                                cur_row <= next_row(cur_row);
                                wr_en   <= 1'b1;
                                wr_addr <= {next_row(cur_row), 6'd0};
                                wr_data <= {in_attr, CH_SP};
                                busy    <= 1'b1;
                                state   <= CLR_LINE;
                            end
                            CH_BS: begin
                                if (cur_col != 6'd0) begin
                                    cur_col     <= cur_col - 6'd1;
                                    wr_en       <= 1'b1;
                                    wr_addr     <= {cur_row, cur_col - 6'd1};
                                    wr_data     <= {in_attr, CH_SP};
                                    adv_pending <= 1'b0;
                                    state       <= PUT;
                                end
                            end
                            CH_FF: begin
                                cur_col <= 6'd0;
                                cur_row <= 5'd0;
                                wr_en   <= 1'b1;
                                wr_addr <= 11'd0;
                                wr_data <= {in_attr, CH_SP};
                                busy    <= 1'b1;
                                state   <= CLR_SCREEN;
                            end
                            default: begin
                                wr_en   <= 1'b1;
                                wr_addr <= {cur_row, cur_col};
                                wr_data <= {in_attr, in_data};
                                state   <= PUT;
                                if (cur_col == COL_MAX) begin
                                    cur_col     <= 6'd0;
                                    cur_row     <= next_row(cur_row);
                                    adv_pending <= 1'b1;
                                end else begin
                                    cur_col     <= cur_col + 6'd1;
                                    adv_pending <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                PUT: begin
                    if (adv_pending) begin
                        // Wrapping onto a new line blanks it, as an LF would.
                        wr_en   <= 1'b1;
                        wr_addr <= {cur_row, 6'd0};
                        wr_data <= {attr, CH_SP};
                        busy    <= 1'b1;
                        state   <= CLR_LINE;
                    end else begin
                        wr_en    <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                CLR_LINE: begin
                    if (wr_addr[5:0] == COL_MAX) begin
                        wr_en    <= 1'b0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wr_addr <= wr_addr + 11'd1;
                    end
                end
                CLR_SCREEN: begin
                    if (!wr_en) begin
                        // Entered straight from reset: first write not issued yet.
                        wr_en   <= 1'b1;
                        wr_addr <= 11'd0;
                        wr_data <= {attr, CH_SP};
                    end else if (wr_addr[5:0] == COL_MAX) begin
                        if (wr_addr[10:6] == ROW_MAX) begin
                            wr_en    <= 1'b0;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            wr_addr <= {wr_addr[10:6] + 5'd1, 6'd0};
                        end
                    end else begin
                        wr_addr <= wr_addr + 11'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_charbuf_writer.sv
// Bench for charbuf_writer: vector table, hand-written corner sequences, randomized bytes against a screen model.
module tb_charbuf_writer;
    localparam int COLS = 60;
    localparam int ROWS = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [7:0]  in_attr = 8'h00;
    logic        in_ready, wr_en, busy;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;

    charbuf_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_attr(in_attr),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int ready_cyc = 0;
    logic [27:0] got_q[$];
    logic [27:0] exp_q[$];
    int m_col = 0;
    int m_row = 0;

`ifdef CHARBUF_CLEAR_ON_RESET_EN
    localparam logic RST_READY = 1'b0;
    localparam logic RST_BUSY  = 1'b1;
`else
    localparam logic RST_READY = 1'b1;
    localparam logic RST_BUSY  = 1'b0;
`endif

    always @(posedge clk) cyc++;

    // Write log entries are {busy, addr, data}.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            got_q.push_back({busy, wr_addr, wr_data});
            last_wr_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [27:0] wr(input logic b, input int r, input int c, input logic [15:0] d);
        logic [10:0] a;
        a = 11'(r * 64 + c);
        return {b, a, d};
    endfunction

    task automatic model_screen_clear(input logic [7:0] a);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(wr(1'b1, r, c, {a, 8'h20}));
    endtask

    task automatic model_byte(input logic [7:0] d, input logic [7:0] a);
        case (d)
            8'h0D: m_col = 0;
            8'h0A: begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                for (int c = 0; c < COLS; c++) exp_q.push_back(wr(1'b1, m_row, c, {a, 8'h20}));
            end
            8'h08: begin
                if (m_col > 0) begin
                    m_col--;
                    exp_q.push_back(wr(1'b0, m_row, m_col, {a, 8'h20}));
                end
            end
            8'h0C: begin
                m_col = 0;
                m_row = 0;
                model_screen_clear(a);
            end
            default: begin
                exp_q.push_back(wr(1'b0, m_row, m_col, {a, d}));
                m_col++;
                if (m_col == COLS) begin
                    m_col = 0;
                    m_row = (m_row + 1) % ROWS;
                    for (int c = 0; c < COLS; c++) exp_q.push_back(wr(1'b1, m_row, c, {a, 8'h20}));
                end
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_attr  = a;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            vectors++;
            errors++;
            $display("FAIL accept timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ready_cyc = cyc;
        if (n >= 3000) begin
            vectors++;
            errors++;
            $display("FAIL idle timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic run_byte(input logic [7:0] d, input logic [7:0] a);
        model_byte(d, a);
        send_byte(d, a);
        wait_idle();
    endtask

    task automatic cmp_writes(input string name);
        int k;
        int n;
        check({name, " write count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        k = -1;
        for (int i = 0; i < n; i++)
            if (k < 0 && got_q[i] !== exp_q[i]) k = i;
        if (n > 0) begin
            if (k < 0) k = n - 1;
            check({name, " write {busy,addr,data}"}, got_q[k], exp_q[k]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_byte(input string name);
        check({name, " cur_col"}, cur_col, m_col);
        check({name, " cur_row"}, cur_row, m_row);
        cmp_writes(name);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  a;
        int          col;
        int          row;
        int          n;
        logic [10:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cnt;
        int r;
        logic [7:0] d;

        // Cursor starts at (0,1) after the hand-driven 'A'.
        tbl[0] = '{8'h42, 8'h1E, 2, 0, 1,  11'h001, 16'h1E42};
        tbl[1] = '{8'h0D, 8'h00, 0, 0, 0,  11'h000, 16'h0000};
        tbl[2] = '{8'h08, 8'h22, 0, 0, 0,  11'h000, 16'h0000};
        tbl[3] = '{8'h00, 8'h33, 1, 0, 1,  11'h000, 16'h3300};
        tbl[4] = '{8'hFF, 8'h44, 2, 0, 1,  11'h001, 16'h44FF};
        tbl[5] = '{8'h08, 8'h55, 1, 0, 1,  11'h001, 16'h5520};
        tbl[6] = '{8'h0A, 8'h66, 0, 1, 60, 11'h040, 16'h6620};
        tbl[7] = '{8'h07, 8'h01, 1, 1, 1,  11'h040, 16'h0107};

        #12;
        check("reset wr_en", wr_en, 1'b0);
        check("reset wr_addr", wr_addr, 11'h000);
        check("reset wr_data", wr_data, 16'h0000);
        check("reset cur_col", cur_col, 6'd0);
        check("reset cur_row", cur_row, 5'd0);
        check("reset busy", busy, RST_BUSY);
        check("reset in_ready", in_ready, RST_READY);
        @(negedge clk);
        rst = 1'b0;
`ifdef CHARBUF_CLEAR_ON_RESET_EN
        model_screen_clear(8'h07);
        wait_idle();
        finish_byte("initial clear");
`endif

        // 'A': one write at N+1, in_ready low for exactly one cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h41;
        in_attr  = 8'h0F;
        check("A in_ready before", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("A wr_en N+1", wr_en, 1'b1);
        check("A wr_addr N+1", wr_addr, 11'h000);
        check("A wr_data N+1", wr_data, 16'h0F41);
        check("A cur_col N+1", cur_col, 6'd1);
        check("A in_ready N+1", in_ready, 1'b0);
        @(negedge clk);
        check("A wr_en N+2", wr_en, 1'b0);
        check("A in_ready N+2", in_ready, 1'b1);
        model_byte(8'h41, 8'h0F);
        cmp_writes("A");

        for (int i = 0; i < 8; i++) begin
            run_byte(tbl[i].d, tbl[i].a);
            check($sformatf("vec%0d cur_col", i), cur_col, tbl[i].col);
            check($sformatf("vec%0d cur_row", i), cur_row, tbl[i].row);
            check($sformatf("vec%0d nwrites", i), got_q.size(), tbl[i].n);
            if (tbl[i].n > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d first addr", i), got_q[0][26:16], tbl[i].addr);
                check($sformatf("vec%0d first data", i), got_q[0][15:0], tbl[i].data);
            end
            cmp_writes($sformatf("vec%0d", i));
        end

        // Backspace at col 3 then at col 0.
        run_byte(8'h0C, 8'h00);
        finish_byte("ff home");
        for (int i = 0; i < 3; i++) begin
            run_byte(8'h61 + 8'(i), 8'h09);
            finish_byte("abc");
        end
        run_byte(8'h08, 8'h21);
        check("bs col", cur_col, 6'd2);
        if (got_q.size() > 0) begin
            check("bs addr", got_q[0][26:16], 11'h002);
            check("bs char", got_q[0][7:0], 8'h20);
        end
        finish_byte("bs");
        run_byte(8'h0D, 8'h00);
        finish_byte("cr");
        run_byte(8'h08, 8'h21);
        check("bs at col0 nwrites", got_q.size(), 0);
        finish_byte("bs col0");

        // 60 printables fill row 0 and wrap, clearing row 1.
        for (int i = 0; i < COLS; i++) begin
            run_byte(8'h78, 8'h2A);
            if (i == COLS - 1) begin
                check("wrap nwrites", got_q.size(), 61);
                if (got_q.size() == 61) begin
                    check("wrap last put", got_q[0][26:16], 11'h03B);
                    check("wrap clear end", got_q[60], {1'b1, 11'h07B, 16'h2A20});
                end
                check("wrap col", cur_col, 6'd0);
                check("wrap row", cur_row, 5'd1);
            end
            finish_byte("fill row");
        end

        // LF from the bottom row wraps to row 0 and leaves row 16 alone.
        for (int i = 0; i < ROWS - 2; i++) begin
            run_byte(8'h0A, 8'h03);
            finish_byte("lf down");
        end
        for (int i = 0; i < 5; i++) begin
            run_byte(8'h30 + 8'(i), 8'h04);
            finish_byte("row16 text");
        end
        check("pre-wrap col", cur_col, 6'd5);
        check("pre-wrap row", cur_row, 5'd16);
        run_byte(8'h0A, 8'h0B);
        cnt = 0;
        foreach (got_q[i]) if (got_q[i][26:22] == 5'd16) cnt++;
        check("lf wrap row16 writes", cnt, 0);
        finish_byte("lf wrap");

        // Full-screen clear: only visible cells, in_ready back right after the last write.
        run_byte(8'h0C, 8'h17);
        cnt = 0;
        foreach (got_q[i])
            if (got_q[i][21:16] >= 6'(COLS) || got_q[i][26:22] >= 5'(ROWS) || got_q[i][15:0] != 16'h1720) cnt++;
        check("ff bad writes", cnt, 0);
        check("ff ready after last write", ready_cyc - last_wr_cyc, 1);
        finish_byte("ff");

        // Reset in the middle of a screen clear.
        send_byte(8'h0C, 8'h17);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-clear rst wr_en", wr_en, 1'b0);
        check("mid-clear rst cur_col", cur_col, 6'd0);
        check("mid-clear rst cur_row", cur_row, 5'd0);
        check("mid-clear rst in_ready", in_ready, RST_READY);
        repeat (2) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        rst = 1'b0;
`ifdef CHARBUF_CLEAR_ON_RESET_EN
        model_screen_clear(8'h07);
`endif
        wait_idle();
        finish_byte("post-reset");

        // Randomized byte stream.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1)       d = 8'h0C;
            else if (r < 7)  d = 8'h0A;
            else if (r < 13) d = 8'h0D;
            else if (r < 23) d = 8'h08;
            else             d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_byte(d, 8'($urandom_range(0, 255)));
            finish_byte($sformatf("rand%0d byte %0h", i, d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
